// File: rtl/uart_fifo_bus.sv
// rtl/uart_fifo_bus.sv - memory-mapped 8N1 UART with TX/RX FIFOs for the 6502 bus
// Single clock domain; the CPU side acts once per chip-select assertion.

module uart_fifo_bus_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
endmodule

module uart_fifo_bus #(
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rwb,
  input  logic [2:0] addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic       rx_i,
  output logic       tx_o,
  output logic       irqb
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic                 r_cs_q, r_irqb;
  logic [3:0]           r_ctrl;
  logic [DIV_WIDTH-1:0] r_div, r_baud_cnt;
  logic                 r_rx_overrun, r_frame_err, r_tx_overflow;
  logic                 r_tx_busy, r_tx_o;
  logic [7:0]           r_tx_data;
  logic [3:0]           r_tx_bit, r_tx_tcnt;
  logic [1:0]           r_sync;
  logic                 r_rx_prev;
  rx_state_t            r_rx_state, w_rx_state_nx;
  logic [3:0]           r_rx_tcnt;
  logic [2:0]           r_rx_bitn;
  logic [7:0]           r_rx_sr;

  logic       w_acc, w_wr, w_rd, w_tick, w_w1c;
  logic       w_txf_push, w_txf_pop, w_txf_empty, w_txf_full, w_tx_push_req, w_tx_end;
  logic       w_rxf_push, w_rxf_empty, w_rxf_full, w_cpu_pop, w_rx_push_req, w_ferr_set;
  logic [7:0] w_txf_rdata, w_rxf_rdata;
  logic       w_rx_line, w_rx_fall, w_tx_idle;

  assign w_acc = cs & ~r_cs_q;
  assign w_wr  = w_acc & ~rwb;
  assign w_rd  = w_acc & rwb;
  assign w_w1c = w_wr & (addr == 3'd1);

  assign w_tick = (r_baud_cnt == '0);

  assign w_tx_end      = r_tx_busy & w_tick & (r_tx_tcnt == 4'd15) & (r_tx_bit == 4'd9);
  assign w_txf_pop     = ~w_txf_empty & (~r_tx_busy | w_tx_end);
  assign w_tx_push_req = w_wr & (addr == 3'd0);
  assign w_txf_push    = w_tx_push_req & (~w_txf_full | w_txf_pop);
  assign w_tx_idle     = w_txf_empty & ~r_tx_busy;

  assign w_rx_line  = r_ctrl[3] ? r_tx_o : r_sync[1];
  assign w_rx_fall  = r_rx_prev & ~w_rx_line;
  assign w_cpu_pop  = w_rd & (addr == 3'd0) & ~w_rxf_empty;
  assign w_rxf_push = w_rx_push_req & (~w_rxf_full | w_cpu_pop);

  uart_fifo_bus_fifo #(.DEPTH(TX_DEPTH)) u_txf (
    .clk(clk), .reset(reset), .i_push(w_txf_push), .i_pop(w_txf_pop), .i_wdata(i_data),
    .o_rdata(w_txf_rdata), .o_empty(w_txf_empty), .o_full(w_txf_full));

  uart_fifo_bus_fifo #(.DEPTH(RX_DEPTH)) u_rxf (
    .clk(clk), .reset(reset), .i_push(w_rxf_push), .i_pop(w_cpu_pop), .i_wdata(r_rx_sr),
    .o_rdata(w_rxf_rdata), .o_empty(w_rxf_empty), .o_full(w_rxf_full));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cs_q        <= 1'b0;
      r_ctrl        <= '0;
      r_div         <= DIV_WIDTH'(DEFAULT_DIV);
      r_baud_cnt    <= '0;
      r_rx_overrun  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_overflow <= 1'b0;
      r_irqb        <= 1'b1;
    end else begin
      r_cs_q     <= cs;
      r_baud_cnt <= w_tick ? r_div : r_baud_cnt - DIV_WIDTH'(1);
      if (w_wr && addr == 3'd2) r_ctrl <= i_data[3:0];
      if (w_wr && addr == 3'd3) r_div[7:0] <= i_data;
      if (w_wr && addr == 3'd4) r_div[DIV_WIDTH-1:8] <= i_data[DIV_WIDTH-9:0];
      // A set event in the same cycle overrides the W1C clear.
      r_rx_overrun  <= (w_rx_push_req & w_rxf_full & ~w_cpu_pop) |
                       (r_rx_overrun & ~(w_w1c & i_data[5]));
      r_frame_err   <= w_ferr_set | (r_frame_err & ~(w_w1c & i_data[6]));
      r_tx_overflow <= (w_tx_push_req & w_txf_full & ~w_txf_pop) |
                       (r_tx_overflow & ~(w_w1c & i_data[7]));
      r_irqb <= ~((r_ctrl[0] & ~w_rxf_empty) | (r_ctrl[1] & w_txf_empty) |
                  (r_ctrl[2] & (r_rx_overrun | r_frame_err | r_tx_overflow)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_busy <= 1'b0;
      r_tx_o    <= 1'b1;
      r_tx_data <= '0;
      r_tx_bit  <= '0;
      r_tx_tcnt <= '0;
    end else if (w_txf_pop) begin
      r_tx_busy <= 1'b1;
      r_tx_data <= w_txf_rdata;
      r_tx_bit  <= '0;
      r_tx_tcnt <= '0;
      r_tx_o    <= 1'b0;
    end else if (w_tx_end) begin
      r_tx_busy <= 1'b0;
    end else if (r_tx_busy && w_tick) begin
      r_tx_tcnt <= r_tx_tcnt + 4'd1;
      if (r_tx_tcnt == 4'd15) begin
        r_tx_bit <= r_tx_bit + 4'd1;
        r_tx_o   <= (r_tx_bit == 4'd8) ? 1'b1 : r_tx_data[r_tx_bit[2:0]];
      end
    end
  end

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_push_req = 1'b0;
    w_ferr_set    = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_state_nx = RX_START;
      RX_START: if (w_tick && r_rx_tcnt == 4'd7) w_rx_state_nx = w_rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && r_rx_tcnt == 4'd15 && r_rx_bitn == 3'd7) w_rx_state_nx = RX_STOP;
      RX_STOP: begin
        if (w_tick && r_rx_tcnt == 4'd15) begin
          w_rx_state_nx = RX_IDLE;
          w_rx_push_req = w_rx_line;
          w_ferr_set    = ~w_rx_line;
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bitn  <= '0;
      r_rx_sr    <= '0;
    end else begin
      r_sync     <= {r_sync[0], rx_i};
      r_rx_prev  <= w_rx_line;
      r_rx_state <= w_rx_state_nx;
      if (w_rx_state_nx != r_rx_state) r_rx_tcnt <= '0;
      else if (w_tick)                 r_rx_tcnt <= r_rx_tcnt + 4'd1;
      if (r_rx_state != RX_DATA) begin
        r_rx_bitn <= '0;
      end else if (w_tick && r_rx_tcnt == 4'd15) begin
        r_rx_sr   <= {w_rx_line, r_rx_sr[7:1]};
        r_rx_bitn <= r_rx_bitn + 3'd1;
      end
    end
  end

  always_comb begin
    o_data = '0;
    case (addr)
      3'd0: if (!w_rxf_empty) o_data = w_rxf_rdata;
      3'd1: o_data = {r_tx_overflow, r_frame_err, r_rx_overrun, w_tx_idle,
                      w_txf_full, w_txf_empty, w_rxf_full, ~w_rxf_empty};
      3'd2: o_data = {4'b0000, r_ctrl};
      3'd3: o_data = r_div[7:0];
      3'd4: o_data[DIV_WIDTH-9:0] = r_div[DIV_WIDTH-1:8];
      default: o_data = '0;
    endcase
  end

  assign tx_o = r_tx_o;
  assign irqb = r_irqb;
endmodule

// File: tb/tb_uart_fifo_bus.sv
// tb/tb_uart_fifo_bus.sv - randomized self-checking bench for uart_fifo_bus

module tb_uart_fifo_bus;
  localparam int RX_DEPTH = 16;
  localparam int TX_DEPTH = 16;
  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b0;
  logic       rwb = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] o_data;
  logic       rx_i = 1'b1;
  logic       tx_o;
  logic       irqb;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] rx_q[$];
  logic [7:0] lb[$];
  logic [7:0] exp_regs [8];
  logic [7:0] rd, b, exp_st;
  logic [9:0] obs;
  logic       ovr, ovf, found;

  uart_fifo_bus #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .DIV_WIDTH(16), .DEFAULT_DIV(26)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rwb(rwb), .addr(addr), .i_data(i_data),
    .o_data(o_data), .rx_i(rx_i), .tx_o(tx_o), .irqb(irqb));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
    @(negedge clk);
    cs = 1'b0; rwb = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rwb = 1'b1; addr = a;
    #1 d = o_data;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic rx_bit(input logic v);
    rx_i = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic rx_body(input logic [7:0] d);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    rx_body(d);
    rx_bit(stop);
    rx_bit(1'b1);
  endtask

  // Expected STATUS with the transmitter fully idle.
  function automatic logic [7:0] model_status(int rx_n, logic o, logic f);
    return {1'b0, f, o, 1'b1, 1'b0, 1'b1, (rx_n >= RX_DEPTH), (rx_n > 0)};
  endfunction

  function automatic logic [9:0] line_frame(logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst_tx_o", 32'(tx_o), 32'd1);
    check("rst_irqb", 32'(irqb), 32'd1);
    exp_regs = '{8'h00, 8'h14, 8'h00, 8'd26, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("rst_reg%0d", a), 32'(rd), 32'(exp_regs[a]));
    end

    bus_write(3'd3, 8'h00);
    repeat (30) @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom);
      bus_write(3'd0, b);
      check("tx_lat_hi", 32'(tx_o), 32'd1);
      @(negedge clk);
      check("tx_lat_lo", 32'(tx_o), 32'd0);
      repeat (8) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        obs[k] = tx_o;
        if (k < 9) repeat (16) @(negedge clk);
      end
      check("tx_frame", 32'(obs), 32'(line_frame(b)));
      repeat (12) @(negedge clk);
      bus_read(3'd1, rd);
      check("tx_idle_status", 32'(rd), 32'(model_status(0, 1'b0, 1'b0)));
    end

    bus_write(3'd3, 8'h03);
    bus_write(3'd2, 8'h08);
    rx_i = 1'b0;
    lb = '{8'h00, 8'hFF, 8'h5A};
    lb.push_back(8'($urandom));
    lb.push_back(8'($urandom));
    foreach (lb[i]) bus_write(3'd0, lb[i]);
    repeat (lb.size() * 10 * BIT_CLKS + 300) @(negedge clk);
    foreach (lb[i]) begin
      bus_read(3'd0, rd);
      check($sformatf("lb_data%0d", i), 32'(rd), 32'(lb[i]));
    end
    bus_read(3'd1, rd);
    check("lb_status", 32'(rd), 32'(model_status(0, 1'b0, 1'b0)));
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    bus_write(3'd2, 8'h00);

    rx_q.delete();
    ovr = 1'b0;
    for (int i = 0; i < RX_DEPTH + 1; i++) begin
      b = 8'($urandom);
      rx_frame(b, 1'b1);
      if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
      else ovr = 1'b1;
    end
    bus_read(3'd1, rd);
    check("ovr_status", 32'(rd), 32'(model_status(rx_q.size(), ovr, 1'b0)));
    bus_write(3'd1, 8'h20);
    bus_read(3'd1, rd);
    check("ovr_w1c", 32'(rd), 32'(model_status(rx_q.size(), 1'b0, 1'b0)));
    while (rx_q.size() > 0) begin
      b = rx_q.pop_front();
      bus_read(3'd0, rd);
      check("ovr_data", 32'(rd), 32'(b));
    end
    bus_read(3'd1, rd);
    check("ovr_drained", 32'(rd), 32'(model_status(0, 1'b0, 1'b0)));

    rx_frame(8'($urandom), 1'b0);
    bus_read(3'd1, rd);
    check("ferr_status", 32'(rd), 32'(model_status(0, 1'b0, 1'b1)));
    bus_write(3'd1, 8'h40);
    bus_read(3'd1, rd);
    check("ferr_w1c", 32'(rd), 32'(model_status(0, 1'b0, 1'b0)));
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    rx_i = 1'b1;
    repeat (300) @(negedge clk);
    bus_read(3'd1, rd);
    check("glitch_status", 32'(rd), 32'(model_status(0, 1'b0, 1'b0)));
    bus_read(3'd0, rd);
    check("glitch_data", 32'(rd), 32'd0);

    bus_write(3'd2, 8'h01);
    @(negedge clk);
    check("irq_idle", 32'(irqb), 32'd1);
    rx_body(8'h33);
    rx_i = 1'b1;
    cs = 1'b1; rwb = 1'b1; addr = 3'd1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_data[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("irq_rx_seen", 32'(found), 32'd1);
    check("irq_pre", 32'(irqb), 32'd1);
    @(negedge clk);
    check("irq_low", 32'(irqb), 32'd0);
    cs = 1'b0;
    @(negedge clk);
    bus_read(3'd0, rd);
    check("irq_data", 32'(rd), 32'h33);
    check("irq_hold", 32'(irqb), 32'd0);
    @(negedge clk);
    check("irq_release", 32'(irqb), 32'd1);
    repeat (2 * BIT_CLKS) @(negedge clk);

    bus_write(3'd2, 8'h04);
    ovf = 1'b0;
    for (int i = 0; i < TX_DEPTH + 2; i++) begin
      bus_write(3'd0, 8'($urandom));
      if (i >= TX_DEPTH + 1) ovf = 1'b1;
    end
    exp_st = {ovf, 7'b000_1000};
    bus_read(3'd1, rd);
    check("ovf_status", 32'(rd), 32'(exp_st));
    check("ovf_irq", 32'(irqb), 32'd0);
    check("ovf_tx_busy", 32'(tx_o), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx_o), 32'd1);
    check("rst_async_irq", 32'(irqb), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(3'd1, rd);
    check("post_rst_status", 32'(rd), 32'h14);
    bus_read(3'd2, rd);
    check("post_rst_ctrl", 32'(rd), 32'h00);
    bus_read(3'd3, rd);
    check("post_rst_baud", 32'(rd), 32'd26);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_fifo_bus.md
Name: uart_fifo_bus

Overview:
- Next-generation memory-mapped UART for the 6502 bus.
- Integrates its own 8N1 TX/RX serialisers, a programmable 16x-oversample baud divisor, and parametrised TX/RX FIFOs.
- Adds sticky error flags, per-source interrupt enables and internal loopback.
- All logic runs in the single `clk` domain; the CPU reaches it through the chip-select decode.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of 2, ≥2.
- RX_DEPTH, 16, RX FIFO entries; power of 2, ≥2.
- DIV_WIDTH, 16, baud divisor width; 9..16.
- DEFAULT_DIV, 26, divisor reset value; oversample tick every DIV+1 clks.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, high during a bus cycle.
- rwb  in  1  1=read, 0=write.
- addr  in  3  register select.
- i_data  in  8  write data.
- o_data  out  8  read data, combinational.
- rx_i  in  1  serial input, asynchronous.
- tx_o  out  1  serial output, idle high.
- irqb  out  1  interrupt, active low, registered.

Behaviour:
- Access strobe: `acc = cs & ~cs_q`. This gives one action per cs assertion regardless of cs width.
- Push, pop and W1C act only on `acc`.
- Register map:
  - 0 DATA. Write pushes TX FIFO. Read returns RX head and pops on `acc`. Reading with RX empty returns 0x00 and does not pop.
  - 1 STATUS (RO except W1C):
    - b0 rx_nempty
    - b1 rx_full
    - b2 tx_empty
    - b3 tx_full
    - b4 tx_idle (FIFO empty and shifter idle)
    - b5 rx_overrun
    - b6 frame_err
    - b7 tx_overflow
    - Writing 1 to b5..b7 clears them.
  - 2 CONTROL (RW): b0 rx_ie, b1 txe_ie, b2 err_ie, b3 loopback; b7..4 read 0.
  - 3 BAUD_LO (RW).
  - 4 BAUD_HI (RW); bits above DIV_WIDTH-8 read 0.
  - 5..7 read 0; writes ignored.
- Reset values:
  - tx_o=1, irqb=1, CONTROL=0, divisor=DEFAULT_DIV.
  - FIFOs empty; all sticky flags 0.
  - Serialisers idle; baud counter 0; rx synchroniser set to 1.
- Baud:
  - Down-counter reloads with the divisor.
  - Tick fires when the counter reaches 0.
  - A divisor write takes effect at the next reload; an in-flight count is not truncated.
- TX:
  - When the shifter is idle and the FIFO is non-empty, it loads the head (pop) and drives tx_o=0 on the next clk.
  - Frame: start, 8 data bits LSB first, stop (1); each bit lasts 16 ticks.
  - Back-to-back FIFO entries produce no idle gap.
- TX FIFO full on push:
  - Data is dropped and tx_overflow is set.
  - If the shifter pops in the same cycle, the push is accepted.
- RX input: rx_i passes through a 2-flop synchroniser. With loopback=1 the source is tx_o; rx_i is ignored and tx_o still drives the pin.
- RX state machine IDLE→START→DATA→STOP:
  - IDLE→START: on a 1→0 edge.
  - START: at tick 8, if the line is 1 it is a glitch → return to IDLE; otherwise go to DATA.
  - DATA: sample every 16 ticks.
  - STOP: sample at the stop bit centre.
    - Stop=0: set frame_err, discard the byte, return to IDLE; wait for the line to be 1 before re-arming.
    - Stop=1: push the byte; rx_nempty is visible on the next clk.
- RX FIFO full at push:
  - Byte dropped; rx_overrun set; FIFO contents unchanged.
  - Exception: a CPU pop in the same cycle makes room, so the byte is accepted.
- irqb is registered and equals `~((rx_ie&rx_nempty) | (txe_ie&tx_empty) | (err_ie&(rx_overrun|frame_err|tx_overflow)))`.
- Counters:
  - FIFO pointers wrap at DEPTH; occupancy uses log2(DEPTH)+1 bits.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- W1C and a flag-set event in the same cycle: set wins.
- Reset asserted mid-frame: tx_o goes to 1 immediately (asynchronous); a partial RX byte is discarded.

Test Plan:
1. Reset, then read all registers → STATUS=0x14, CONTROL=0x00, BAUD_LO/HI=DEFAULT_DIV; tx_o=1, irqb=1.
2. Divisor=0, write 0xA5 to DATA → tx_o low 2 clks after acc; bit pattern 0,1,0,1,0,0,1,0,1,1, each 16 clks; STATUS b4 returns to 1 after the stop bit.
3. Loopback=1, divisor=3, push 0x00,0xFF,0x5A → RX pops return the same bytes in order; no error flags.
4. Drive RX_DEPTH+1 frames on rx_i without reading → rx_full=1, rx_overrun=1, the first RX_DEPTH bytes intact; W1C 0x20 to STATUS clears b5.
5. rx_i frame with stop bit 0 → frame_err=1, rx_nempty=0. Separately, a 4-tick low glitch on idle rx_i → nothing received.
6. CONTROL=0x01, receive 0x33 → irqb low 1 clk after rx_nempty rises; pop → irqb high the following clk. Separately, assert reset mid-TX → tx_o=1 the same instant.
